// File: rtl/wb_periph_bridge.sv
// wb_periph_bridge: Wishbone fan-out to SLAVES slots with registered responses, watchdog and error capture
module wb_periph_bridge #(
    parameter int          SLAVES    = 16,
    parameter int          SLOT_BITS = 8,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF,
    parameter bit          ERR_ACK   = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic [29:0]          adr_i,
    output logic                 ack_o,
    output logic                 err_o,
    output logic [31:0]          dat_o,
    output logic [SLAVES-1:0]    slv_stb_o,
    input  logic [SLAVES-1:0]    slv_ack_i,
    input  logic [SLAVES*32-1:0] slv_dat_i,
    output logic [29:0]          err_adr_o,
    output logic [7:0]           err_cnt_o
);
    localparam int IDX_W = SLAVES > 1 ? $clog2(SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP, ERROR} state_t;

    state_t            state, nxt;
    logic [IDX_W-1:0]  idx, sidx, nidx;
    logic [29:0]       adr_q;
    logic [31:0]       wd;
    logic              hit, ack_sel, nack, nerr;
    logic [SLAVES-1:0] nstb;
    logic [31:0]       ndat;
    logic [31:0]       dat_arr [SLAVES];

    for (genvar k = 0; k < SLAVES; k++) begin : g_dat
        assign dat_arr[k] = slv_dat_i[32*k +: 32];
    end

    assign sidx    = adr_i[SLOT_BITS+IDX_W-1:SLOT_BITS];
    assign nidx    = state == IDLE ? sidx : idx;
    assign hit     = 32'(sidx) < 32'(SLAVES);
    assign ack_sel = slv_ack_i[idx];

    // State register; request context is latched while idle, watchdog counts ACTIVE cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            idx   <= '0;
            adr_q <= '0;
            wd    <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE) begin
                idx   <= sidx;
                adr_q <= adr_i;
            end
            wd <= state == ACTIVE ? wd + 32'd1 : 32'd0;
        end
    end

    // Next state: abort beats ack, ack beats watchdog expiry
    always_comb begin
        nxt = IDLE;
        unique case (state)
            IDLE:    nxt = !(cyc_i && stb_i) ? IDLE : hit ? ACTIVE : ERROR;
            ACTIVE:  nxt = !cyc_i ? IDLE : ack_sel ? RESP :
                           (TIMEOUT != 0 && wd == 32'(TIMEOUT - 1)) ? ERROR : ACTIVE;
            default: nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state
    always_comb begin
        nack = nxt == RESP || (nxt == ERROR && ERR_ACK);
        nerr = nxt == ERROR;
        nstb = nxt == ACTIVE ? SLAVES'(1) << nidx : '0;
        ndat = nxt == ERROR ? ERR_DATA : nxt == RESP ? dat_arr[idx] : dat_o;
    end

    // Output registers and fault capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            slv_stb_o <= '0;
            dat_o     <= '0;
            err_adr_o <= '0;
            err_cnt_o <= '0;
        end else begin
            ack_o     <= nack;
            err_o     <= nerr;
            slv_stb_o <= nstb;
            dat_o     <= ndat;
            if (nerr) begin
                err_adr_o <= state == IDLE ? adr_i : adr_q;
                err_cnt_o <= err_cnt_o + {7'd0, err_cnt_o != 8'hFF};
            end
        end
    end
endmodule

// File: tb/tb_wb_periph_bridge.sv
// tb_wb_periph_bridge: randomized self-checking bench for wb_periph_bridge against an outcome model
module tb_wb_periph_bridge;
    localparam int SL = 5;
    localparam int SB = 8;
    localparam int TO = 255;
    localparam logic [31:0] ED = 32'hDEADBEEF;

    logic             clk = 1'b0;
    logic             rst, cyc, stb;
    logic [29:0]      adr;
    logic             ack, err;
    logic [31:0]      dat;
    logic [SL-1:0]    sstb, sack, spur;
    logic [SL*32-1:0] sdat;
    logic [29:0]      eadr;
    logic [7:0]       ecnt;

    int          delay [SL];
    logic [31:0] data  [SL];
    int          cnt   [SL];

    int total = 0;
    int bad   = 0;
    int ref_cnt = 0;
    logic [29:0] ref_adr = '0;

    bit          o_ack, o_err, o_bad;
    logic [31:0] o_dat;
    int          o_lat, o_stb, o_extra;

    bit          e_ack, e_err;
    logic [31:0] e_dat;
    int          e_lat, e_stb;

    always #5 clk = ~clk;

    wb_periph_bridge #(.SLAVES(SL), .SLOT_BITS(SB), .TIMEOUT(TO), .ERR_DATA(ED), .ERR_ACK(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .adr_i(adr),
        .ack_o(ack), .err_o(err), .dat_o(dat),
        .slv_stb_o(sstb), .slv_ack_i(sack), .slv_dat_i(sdat),
        .err_adr_o(eadr), .err_cnt_o(ecnt)
    );

    for (genvar g = 0; g < SL; g++) begin : g_slv
        assign sack[g] = (sstb[g] && cnt[g] == delay[g]) | spur[g];
        assign sdat[32*g +: 32] = data[g];
        always @(posedge clk) cnt[g] <= sstb[g] ? cnt[g] + 1 : 0;
    end

    function automatic logic [29:0] mk_adr(input int slot);
        logic [29:0] a;
        a = 30'($urandom);
        a[SB+2:SB] = 3'(slot);
        return a;
    endfunction

    // Outcome of one access from slot mapping and the slave's ack delay
    task automatic model(input logic [29:0] a);
        int k;
        k = int'(a[SB+2:SB]);
        if (k >= SL) begin
            e_ack = 1; e_err = 1; e_dat = ED; e_lat = 1; e_stb = 0;
        end else if (delay[k] >= 0 && delay[k] < TO) begin
            e_ack = 1; e_err = 0; e_dat = data[k]; e_lat = delay[k] + 2; e_stb = delay[k] + 1;
        end else begin
            e_ack = 1; e_err = 1; e_dat = ED; e_lat = TO + 1; e_stb = TO;
        end
        if (e_err) begin
            ref_cnt = ref_cnt < 255 ? ref_cnt + 1 : 255;
            ref_adr = a;
        end
    endtask

    // Drive one access and record what the bridge did
    task automatic run(input logic [29:0] a, input int spur_slot);
        int k;
        k = int'(a[SB+2:SB]);
        o_ack = 0; o_err = 0; o_bad = 0; o_dat = '0; o_lat = 0; o_stb = 0; o_extra = 0;
        @(negedge clk);
        cyc = 1; stb = 1; adr = a;
        for (int n = 1; n <= TO + 10 && !(o_ack || o_err); n++) begin
            @(posedge clk); #1;
            if (spur_slot >= 0) spur = n == 2 ? SL'(1) << spur_slot : '0;
            if (sstb != 0 && (k >= SL || sstb != (SL'(1) << k))) o_bad = 1;
            if (k < SL && sstb[k]) o_stb++;
            if (ack || err) begin
                o_ack = ack; o_err = err; o_dat = dat; o_lat = n;
            end
        end
        spur = '0; cyc = 0; stb = 0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (ack || err) o_extra++;
            if (sstb != 0) o_bad = 1;
        end
    endtask

    task automatic test_reset;
        rst = 1; cyc = 0; stb = 0; adr = '0; spur = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 0;
        #1;
        total++; if ({ack, err} !== 2'b00) begin bad++; $display("FAIL reset_ack_err got=%b want=00", {ack, err}); end
        total++; if (dat !== 32'd0) begin bad++; $display("FAIL reset_dat got=%h want=0", dat); end
        total++; if (sstb !== '0) begin bad++; $display("FAIL reset_stb got=%b want=0", sstb); end
        total++; if ({eadr, ecnt} !== 38'd0) begin bad++; $display("FAIL reset_errinfo got=%h/%0d want=0/0", eadr, ecnt); end
    endtask

    task automatic test_basic;
        logic [29:0] a;
        a = 30'(2 << SB);
        delay[2] = 0; data[2] = 32'h12345678;
        model(a); run(a, -1);
        total++; if (o_lat !== 2) begin bad++; $display("FAIL basic_latency got=%0d want=2", o_lat); end
        total++; if ({o_ack, o_err} !== 2'b10) begin bad++; $display("FAIL basic_ack_err got=%b want=10", {o_ack, o_err}); end
        total++; if (o_dat !== 32'h12345678) begin bad++; $display("FAIL basic_dat got=%h want=12345678", o_dat); end
        total++; if (o_extra !== 0 || o_bad) begin bad++; $display("FAIL basic_extra got=%0d/%0b want=0/0", o_extra, o_bad); end
    endtask

    task automatic test_timeout;
        logic [29:0] a;
        a = mk_adr(4);
        delay[4] = -1;
        model(a); run(a, -1);
        total++; if (o_stb !== TO) begin bad++; $display("FAIL timeout_stb_cycles got=%0d want=%0d", o_stb, TO); end
        total++; if ({o_ack, o_err, o_dat} !== {2'b11, ED}) begin bad++; $display("FAIL timeout_resp got=%b%b %h want=11 %h", o_ack, o_err, o_dat, ED); end
        total++; if (eadr !== a) begin bad++; $display("FAIL timeout_err_adr got=%h want=%h", eadr, a); end
        total++; if (ecnt !== 8'd1) begin bad++; $display("FAIL timeout_err_cnt got=%0d want=1", ecnt); end
    endtask

    task automatic test_unmapped;
        logic [29:0] a;
        a = mk_adr(7);
        model(a); run(a, -1);
        total++; if (o_bad || o_stb !== 0) begin bad++; $display("FAIL unmapped_stb got=%0b/%0d want=0/0", o_bad, o_stb); end
        total++; if (o_lat !== 1 || o_err !== 1) begin bad++; $display("FAIL unmapped_err got=%0d/%0b want=1/1", o_lat, o_err); end
        total++; if (ecnt !== 8'(ref_cnt) || eadr !== a) begin bad++; $display("FAIL unmapped_errinfo got=%0d/%h want=%0d/%h", ecnt, eadr, ref_cnt, a); end
    endtask

    task automatic test_spurious;
        logic [29:0] a;
        a = mk_adr(3);
        delay[3] = 4; data[3] = 32'hC0FFEE03; data[1] = 32'hBAD00001; delay[1] = -1;
        model(a); run(a, 1);
        total++; if (o_dat !== 32'hC0FFEE03) begin bad++; $display("FAIL spurious_dat got=%h want=c0ffee03", o_dat); end
        total++; if (o_lat !== 6 || o_extra !== 0 || o_bad) begin bad++; $display("FAIL spurious_single got=%0d/%0d/%0b want=6/0/0", o_lat, o_extra, o_bad); end
    endtask

    task automatic test_boundary;
        logic [29:0] a;
        a = mk_adr(0);
        delay[0] = TO - 1; data[0] = $urandom;
        model(a); run(a, -1);
        total++; if ({o_ack, o_err, o_dat, o_lat} !== {2'b10, data[0], 32'(TO + 1)}) begin bad++; $display("FAIL boundary_ack_wins got=%b%b %h %0d want=10 %h %0d", o_ack, o_err, o_dat, o_lat, data[0], TO + 1); end
        delay[0] = TO;
        model(a); run(a, -1);
        total++; if ({o_ack, o_err, o_dat, o_lat} !== {2'b11, ED, 32'(TO + 1)}) begin bad++; $display("FAIL boundary_late_ack got=%b%b %h %0d want=11 %h %0d", o_ack, o_err, o_dat, o_lat, ED, TO + 1); end
    endtask

    task automatic test_abort;
        bit seen;
        delay[1] = -1; delay[2] = -1;
        @(negedge clk); cyc = 1; stb = 1; adr = mk_adr(1);
        repeat (5) @(posedge clk); #1;
        total++; if (sstb !== 5'b00010) begin bad++; $display("FAIL abort_active_stb got=%b want=00010", sstb); end
        cyc = 0; stb = 0; seen = 0;
        repeat (5) begin @(posedge clk); #1; if (ack || err || sstb != 0) seen = 1; end
        total++; if (seen) begin bad++; $display("FAIL abort_quiet got=1 want=0"); end
        @(negedge clk); cyc = 1; stb = 1; adr = mk_adr(2);
        repeat (3) @(posedge clk); #2;
        rst = 1; #1;
        total++; if ({ack, err, dat, sstb, eadr, ecnt} !== '0) begin bad++; $display("FAIL async_reset got=%b%b %h %b %h %0d want=all0", ack, err, dat, sstb, eadr, ecnt); end
        ref_cnt = 0; ref_adr = '0;
        cyc = 0; stb = 0;
        @(negedge clk); rst = 0;
    endtask

    task automatic test_random;
        logic [29:0] a;
        int s;
        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 7);
            if (s < SL) begin
                delay[s] = $urandom_range(0, 9) == 0 ? -1 : $urandom_range(0, 6);
                data[s] = $urandom;
            end
            a = mk_adr(s);
            model(a); run(a, -1);
            total++;
            if ({o_ack, o_err, o_dat, o_lat, o_stb, o_extra, o_bad} !== {e_ack, e_err, e_dat, e_lat, e_stb, 32'd0, 1'b0}) begin
                bad++;
                $display("FAIL random_%0d slot=%0d got=%b%b %h lat=%0d stb=%0d x=%0d b=%0b want=%b%b %h lat=%0d stb=%0d", i, s, o_ack, o_err, o_dat, o_lat, o_stb, o_extra, o_bad, e_ack, e_err, e_dat, e_lat, e_stb);
            end
            total++;
            if ({ecnt, eadr} !== {8'(ref_cnt), ref_adr}) begin
                bad++;
                $display("FAIL random_errinfo_%0d got=%0d/%h want=%0d/%h", i, ecnt, eadr, ref_cnt, ref_adr);
            end
        end
    endtask

    task automatic test_saturate;
        logic [29:0] a;
        for (int i = 0; i < 300; i++) begin
            a = mk_adr($urandom_range(SL, 7));
            model(a); run(a, -1);
        end
        total++; if (ecnt !== 8'd255 || ref_cnt != 255) begin bad++; $display("FAIL saturate_cnt got=%0d want=255", ecnt); end
        a = mk_adr(4); delay[4] = -1;
        model(a); run(a, -1);
        total++; if (ecnt !== 8'd255 || eadr !== a || o_err !== 1) begin bad++; $display("FAIL saturate_hold got=%0d/%h/%0b want=255/%h/1", ecnt, eadr, o_err, a); end
    endtask

    initial begin
        for (int k = 0; k < SL; k++) begin
            delay[k] = 0;
            data[k] = 32'hA5000000 | 32'(k);
        end
        test_reset;
        test_basic;
        test_timeout;
        test_unmapped;
        test_spurious;
        test_boundary;
        test_abort;
        test_random;
        test_saturate;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
